// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor: LANES x WIDTH-bit a - b with per-lane borrow / signed-overflow flags.
// Latency: a beat presented in cycle N is on the outputs in cycle N+STAGES (STAGES register stages).
// Backpressure: bubble-collapsing valid/ready; with out_ready low, STAGES beats fill before in_ready drops.
// Optional macro SUB_SATURATE_EN: clamp out_diff on signed overflow (in_signed=1) or borrow (in_signed=0).
module pipelined_subtractor #(
  parameter int WIDTH  = 12,
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic                   in_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_diff,
  output logic [LANES-1:0]       out_borrow,
  output logic [LANES-1:0]       out_ovf
);

  // Stage payload: {diff, borrow, ovf}. All arithmetic is resolved before stage 0,
  // so the later stages are pure storage and the outputs come straight from flops.
  localparam int DW = LANES*WIDTH + 2*LANES;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [DW-1:0]     dat_q [STAGES];
  logic [DW-1:0]     dat_d [STAGES];
  logic [STAGES-1:0] adv;

  logic [LANES*WIDTH-1:0] res_diff;
  logic [LANES-1:0]       res_borrow;
  logic [LANES-1:0]       res_ovf;

`ifndef SUB_SATURATE_EN
  // Beat mode only steers saturation; in the wrapping build it is ignored.
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
`endif

  // Per-lane a + ~b + 1 with carry-out, raw flags, and optional clamp of the data.
  always_comb begin
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;
    logic [WIDTH:0]   sum;
    logic             brw;
    logic             ovf;
    res_diff   = '0;
    res_borrow = '0;
    res_ovf    = '0;
    for (int i = 0; i < LANES; i++) begin
      a_l = in_a[i*WIDTH +: WIDTH];
      b_l = in_b[i*WIDTH +: WIDTH];
      sum = {1'b0, a_l} + {1'b0, ~b_l} + {{WIDTH{1'b0}}, 1'b1};
      brw = ~sum[WIDTH];
      ovf = (a_l[WIDTH-1] != b_l[WIDTH-1]) && (sum[WIDTH-1] != a_l[WIDTH-1]);
      res_diff[i*WIDTH +: WIDTH] = sum[WIDTH-1:0];
`ifdef SUB_SATURATE_EN
      if (in_signed && ovf) begin
        // Overflow direction follows the sign of a: positive a saturates high.
        res_diff[i*WIDTH +: WIDTH] = a_l[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                  : {1'b0, {(WIDTH-1){1'b1}}};
      end else if (!in_signed && brw) begin
        res_diff[i*WIDTH +: WIDTH] = '0;
      end
`endif
      res_borrow[i] = brw;
      res_ovf[i]    = ovf;
    end
  end

  // Stage k moves when any stage at or after k is empty, or the sink takes a beat.
  always_comb begin
    logic any_empty;
    any_empty = 1'b0;
    adv       = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      any_empty = any_empty | ~vld_q[k];
      adv[k]    = any_empty | out_ready;
    end
  end

  assign in_ready = rst_n & adv[0];

  // Next state of each stage: load from upstream when advancing, otherwise hold.
  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < STAGES; k++) begin
      dat_d[k] = dat_q[k];
    end
    if (adv[0]) begin
      vld_d[0] = in_valid;
      dat_d[0] = {res_diff, res_borrow, res_ovf};
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        vld_d[k] = vld_q[k-1];
        dat_d[k] = dat_q[k-1];
      end
    end
  end

  // Pipeline registers; reset empties every stage and zeroes the payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign {out_diff, out_borrow, out_ovf} = dat_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Scoreboard bench for pipelined_subtractor (WIDTH=12, LANES=4, STAGES=2).
// Expected beats are queued at input transfer; a negedge monitor checks every presented output.
// Covers basic, borrow, overflow, lane independence, b=0, backpressure and mid-stream reset.
module tb_pipelined_subtractor;
  localparam int W = 12;
  localparam int L = 4;
  localparam int S = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [L*W-1:0]  in_a = '0;
  logic [L*W-1:0]  in_b = '0;
  logic            in_signed = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [L*W-1:0]  out_diff;
  logic [L-1:0]    out_borrow;
  logic [L-1:0]    out_ovf;

  pipelined_subtractor #(.WIDTH(W), .LANES(L), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [L*W-1:0] diff;
    logic [L-1:0]   borrow;
    logic [L-1:0]   ovf;
    logic           lat;
    logic           consec;
    logic [31:0]    ecyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;
  int accepted = 0;
  int last_pop = -10;

  // Hand-computed differences; lanes written {lane3, lane2, lane1, lane0}.
`ifdef SUB_SATURATE_EN
  localparam logic [47:0] BOR_D  = {12'h000, 12'h000, 12'h7FF, 12'h000};
  localparam logic [47:0] OVF_D  = {12'h000, 12'h000, 12'h7FF, 12'h800};
  localparam logic [47:0] LANE_D = {12'h7FF, 12'h000, 12'hFFF, 12'h001};
`else
  localparam logic [47:0] BOR_D  = {12'h000, 12'h000, 12'h7FF, 12'hFFE};
  localparam logic [47:0] OVF_D  = {12'h000, 12'h000, 12'h800, 12'h7FF};
  localparam logic [47:0] LANE_D = {12'hFFF, 12'h000, 12'hFFF, 12'h001};
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding beat.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: out_valid=1 diff=0x%0h with nothing outstanding (cycle %0d)",
                 out_diff, cyc);
      end else begin
        chk("diff", {16'h0, out_diff}, {16'h0, sb[0].diff});
        chk("borrow", {60'h0, out_borrow}, {60'h0, sb[0].borrow});
        chk("ovf", {60'h0, out_ovf}, {60'h0, sb[0].ovf});
        if (out_ready) begin
          if (sb[0].lat) chk("latency_cycle", 64'(cyc), {32'h0, sb[0].ecyc});
          if (sb[0].consec) chk("burst_gap", 64'(cyc), 64'(last_pop + 1));
          last_pop = cyc;
          void'(sb.pop_front());
        end
      end
    end
  end

  // Present one beat and hold it until accepted; queue its expectation at transfer.
  task automatic send(input logic [47:0] a, input logic [47:0] b, input logic sg,
                      input logic [47:0] ed, input logic [3:0] eb, input logic [3:0] eo,
                      input logic lat, input logic consec);
    exp_t e;
    bit   done;
    done = 1'b0;
    in_a = a;
    in_b = b;
    in_signed = sg;
    in_valid = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.diff = ed;
        e.borrow = eb;
        e.ovf = eo;
        e.lat = lat;
        e.consec = consec;
        e.ecyc = 32'(cyc + S);
        sb.push_back(e);
        accepted++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected acceptance within 64 cycles");
    end
  endtask

  // Wait for all outstanding beats to leave, then confirm the output goes idle.
  task automatic drain();
    for (int t = 0; t < 200 && sb.size() > 0; t++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
    end
    @(negedge clk);
    chk("idle_out_valid", {63'h0, out_valid}, 64'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] v;
    // Reset state
    #12;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
    chk("rst_out_diff", {16'h0, out_diff}, 64'h0);
    chk("rst_flags", {56'h0, out_borrow, out_ovf}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic, with latency check
    send({12'h0, 12'h0, 12'h0, 12'h005}, {12'h0, 12'h0, 12'h0, 12'h003}, 1'b0,
         {12'h0, 12'h0, 12'h0, 12'h002}, 4'b0000, 4'b0000, 1'b1, 1'b0);
    drain();

    // Back-to-back directed vectors: borrow, overflow, lane independence, b = 0, a = b
    send({12'h0, 12'h0, 12'h800, 12'h003}, {12'h0, 12'h0, 12'h001, 12'h005}, 1'b0,
         BOR_D, 4'b0001, 4'b0010, 1'b1, 1'b0);
    send({12'h0, 12'h0, 12'h7FF, 12'h800}, {12'h0, 12'h0, 12'hFFF, 12'h001}, 1'b1,
         OVF_D, 4'b0010, 4'b0011, 1'b0, 1'b1);
    send({12'h7FF, 12'hFFF, 12'h000, 12'h100}, {12'h800, 12'hFFF, 12'h001, 12'h0FF}, 1'b1,
         LANE_D, 4'b1010, 4'b1000, 1'b0, 1'b1);
    send({12'hABC, 12'hFFF, 12'h800, 12'h123}, 48'h0, 1'b0,
         {12'hABC, 12'hFFF, 12'h800, 12'h123}, 4'b0000, 4'b0000, 1'b0, 1'b1);
    send({12'h800, 12'h7FF, 12'hFFF, 12'h555}, {12'h800, 12'h7FF, 12'hFFF, 12'h555}, 1'b1,
         48'h0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    drain();

    // Backpressure: out_ready low for 5 cycles while 6 beats are offered
    out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          v = 12'(i);
          send({v, v, v, v}, 48'h0, 1'b0, {v, v, v, v}, 4'b0000, 4'b0000, 1'b0, i > 0);
        end
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        chk("bp_accepted", 64'(accepted), 64'd2);
        chk("bp_in_ready", {63'h0, in_ready}, 64'h0);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream with two beats in flight
    out_ready = 1'b0;
    send({12'h0, 12'h0, 12'h0, 12'h00A}, 48'h0, 1'b0, {12'h0, 12'h0, 12'h0, 12'h00A}, 4'b0, 4'b0, 1'b0, 1'b0);
    send({12'h0, 12'h0, 12'h0, 12'h00B}, 48'h0, 1'b0, {12'h0, 12'h0, 12'h0, 12'h00B}, 4'b0, 4'b0, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("mid_rst_in_ready", {63'h0, in_ready}, 64'h0);
    chk("mid_rst_out_diff", {16'h0, out_diff}, 64'h0);
    sb.delete();
    out_ready = 1'b1;
    #10 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send({12'h0, 12'h0, 12'h0, 12'h005}, {12'h0, 12'h0, 12'h0, 12'h003}, 1'b0,
         {12'h0, 12'h0, 12'h0, 12'h002}, 4'b0000, 4'b0000, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_subtractor.md
Name: pipelined_subtractor

Overview:
- Parametrised successor of the team's fixed 12-bit subtractor.
- Computes a - b as a + (~b + 1) on LANES independent lanes of WIDTH bits each.
- Pipelined over STAGES register stages with a valid/ready handshake; reports per-lane borrow and signed-overflow flags.
- Sits between the PE accumulator outputs and the requantise/bias-subtract path of the TPU datapath.

Parameters:
- WIDTH, 12, bits per lane operand/result (>= 2)
- LANES, 4, number of independent subtract lanes (>= 1)
- STAGES, 2, pipeline register stages from input to output (1..4)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts input this cycle
- in_a  input  LANES*WIDTH  minuends, lane i at [i*WIDTH +: WIDTH]
- in_b  input  LANES*WIDTH  subtrahends, same packing
- in_signed  input  1  beat mode: 1 = two's-complement, 0 = unsigned (affects saturation only)
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- out_diff  output  LANES*WIDTH  differences, same packing
- out_borrow  output  LANES  per lane: 1 when unsigned a < b
- out_ovf  output  LANES  per lane: 1 on signed overflow of a - b

Behaviour:
- Reset is asynchronous and active-low, on a single clock domain clk.
- While rst_n = 0: every stage valid bit = 0; out_valid = 0; out_diff, out_borrow, out_ovf = 0.
- in_ready is combinational: in_ready = 0 during reset, 1 otherwise when stage 0 can accept.
- Arithmetic, per lane:
  - Form a + ~b + 1 at WIDTH+1 bits; carry-out c.
  - diff = low WIDTH bits (modulo 2^WIDTH).
  - borrow = ~c.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - Flags are always computed, regardless of in_signed.
- Pipeline:
  - Each stage holds a valid bit plus data (a/b or partial results, in_signed).
  - Arithmetic may be split across stages freely.
  - Only the final stage drives the out_* signals, directly from registers.
  - Unstalled latency is exactly STAGES cycles: a beat accepted at edge N shows out_valid = 1 after edge N+STAGES.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_valid and out_* must hold stable while out_valid && !out_ready.
- Flow control is bubble-collapsing:
  - Stage k advances when it is empty or stage k+1 advances.
  - The last stage advances when it is empty or out_ready = 1.
  - in_ready = stage 0 advances.
  - With out_ready held at 0, exactly STAGES beats are absorbed before in_ready drops.
- Boundary cases:
  - Simultaneous accept and output transfer while full: throughput is 1 beat/cycle with no bubble.
  - in_valid = 0: bubbles propagate, and out_valid = 0 for those slots.
  - Beats leave in acceptance order; none are dropped or duplicated.
  - Reset mid-operation discards all in-flight beats; none appear after release.
  - a = b gives diff 0, borrow 0, ovf 0.
  - b = 0 gives diff = a, borrow 0.

Optional Feature:
- Macro: SUB_SATURATE_EN.
- Defined:
  - in_signed = 1 and ovf = 1: out_diff clamps to the signed max (0x7FF for WIDTH = 12) when a is non-negative, else the signed min (0x800).
  - in_signed = 0 and borrow = 1: out_diff clamps to 0.
  - out_borrow and out_ovf still report the raw, pre-clamp condition.
  - Latency is unchanged.
- Undefined: out_diff always wraps modulo 2^WIDTH; in_signed has no effect on data.

Test Plan (WIDTH=12, LANES=4, STAGES=2):
- Basic: lane0 a=0x005, b=0x003, out_ready=1 -> 2 cycles later out_diff lane0=0x002, borrow=0, ovf=0, out_valid pulses 1 cycle.
- Borrow: a=0x003, b=0x005, in_signed=0 -> diff=0xFFE, borrow=1, ovf=0; with SUB_SATURATE_EN diff=0x000.
- Signed overflow: a=0x800, b=0x001, in_signed=1 -> diff=0x7FF, ovf=1, borrow=0; with SUB_SATURATE_EN diff=0x800.
  - Also a=0x7FF, b=0xFFF -> wrap diff=0x800 (ovf=1); with SUB_SATURATE_EN diff=0x7FF.
- Backpressure: stream 6 beats with a=i, b=0 while out_ready=0 for 5 cycles -> in_ready drops after 2 accepted beats, out_diff stays 0x000 stable; on release all 6 results emerge in order 0..5, one per cycle.
- Lane independence: lanes a={0x100,0x000,0xFFF,0x7FF}, b={0x0FF,0x001,0xFFF,0x800} -> diff={0x001,0xFFF,0x000,0xFFF}, borrow={0,1,0,1}, ovf={0,0,0,1}.
- Reset mid-stream: two beats in flight, pulse rst_n low for 1 cycle asynchronously -> out_valid=0 immediately, no stale result after release, next accepted beat has latency 2.
